// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and status-register bit positions.
package alu_iter_pkg;

    localparam logic [2:0] OP_MULU = 3'd0;
    localparam logic [2:0] OP_MULS = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_DIVS = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int ST_Z   = 0;
    localparam int ST_N   = 1;
    localparam int ST_V   = 2;
    localparam int ST_DZ  = 3;
    localparam int ST_ILL = 4;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/alu_sign_fix.sv
// Conditional two's-complement negate. Used to take operand magnitudes on
// entry and to restore result signs once the unsigned iteration is done.
module alu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes
// (shift-add multiply, restoring divide), then a single sign-fix/flag cycle.
// Build option: define ALU_DIV_EN to include the divider; without it the
// divide op codes are reported as illegal and no divider logic is built.
module alu_iter_muldiv
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [7:0]       status
);

    function automatic logic op_legal(input logic [2:0] o);
`ifdef ALU_DIV_EN
        return o <= OP_DIVS;
`else
        return o <= OP_MULS;
`endif
    endfunction

    state_e             state_q, state_d;
    logic               hold_q, hold_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [7:0]         status_q, status_d;
    logic               done_q, done_d;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH:0]     div_shift, div_diff;
`endif

    logic               in_fix, accept, in_signed, short_path;
    logic [2*WIDTH-1:0] wide_in, wide_out;
    logic               wide_neg;
    logic [WIDTH-1:0]   narrow_in, narrow_out;
    logic               narrow_neg;
    logic [WIDTH:0]     mul_sum;

    assign in_fix    = (state_q == FIX);
    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == RUN) || in_fix;
    assign accept    = ready && start;
    assign in_signed = op_is_signed(op);
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign status    = status_q;

    // Zero divisors skip the iteration; their result needs no arithmetic.
`ifdef ALU_DIV_EN
    assign short_path = !op_legal(op) || (op_is_div(op) && (b == '0));
`else
    assign short_path = !op_legal(op);
`endif

    // The two negators are time-shared: operand magnitudes on the accept
    // edge, result sign restore while in FIX (the two never overlap).
    assign wide_in    = in_fix ? (op_is_div(op_q) ? {{WIDTH{1'b0}}, mq_q} : {acc_q, mq_q})
                               : {{WIDTH{1'b0}}, a};
    assign wide_neg   = in_fix ? neg_res_q : (in_signed && a[WIDTH-1]);
    assign narrow_in  = in_fix ? acc_q : b;
    assign narrow_neg = in_fix ? neg_rem_q : (in_signed && b[WIDTH-1]);

    alu_sign_fix #(.W(2*WIDTH)) u_fix_wide (
        .val (wide_in),
        .neg (wide_neg),
        .res (wide_out)
    );

    alu_sign_fix #(.W(WIDTH)) u_fix_narrow (
        .val (narrow_in),
        .neg (narrow_neg),
        .res (narrow_out)
    );

    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_DIV_EN
    assign div_shift = {acc_q, mq_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
`endif

    // Next state, one iteration step per RUN cycle, result formation in FIX
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        status_d  = status_q;
        done_d    = 1'b0;
`ifdef ALU_DIV_EN
        a_raw_d   = a_raw_q;
`endif
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef ALU_DIV_EN
                if (op_is_div(op_q)) begin
                    // Restoring step: keep the trial subtraction only if it did not borrow.
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                // Short-path ops spend one extra cycle here to keep their fixed two-edge latency.
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    status_d = '0;
                    if (!op_legal(op_q)) begin
                        res_lo_d         = '0;
                        res_hi_d         = '0;
                        status_d[ST_ILL] = 1'b1;
                    end
`ifdef ALU_DIV_EN
                    else if (op_is_div(op_q)) begin
                        if (opb_q == '0) begin
                            res_lo_d        = '1;
                            res_hi_d        = a_raw_q;
                            status_d[ST_DZ] = 1'b1;
                        end else begin
                            res_lo_d       = wide_out[WIDTH-1:0];
                            res_hi_d       = narrow_out;
                            // Only most-negative / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
                            status_d[ST_V] = (op_q == OP_DIVS) && !neg_res_q && mq_q[WIDTH-1];
                        end
                    end
`endif
                    else begin
                        res_lo_d       = wide_out[WIDTH-1:0];
                        res_hi_d       = wide_out[2*WIDTH-1:WIDTH];
                        status_d[ST_V] = (op_q == OP_MULS)
                                       ? (wide_out[2*WIDTH-1:WIDTH] != {WIDTH{wide_out[WIDTH-1]}})
                                       : (wide_out[2*WIDTH-1:WIDTH] != '0);
                    end
                    if (op_legal(op_q)) begin
                        status_d[ST_Z] = (res_lo_d == '0);
                        status_d[ST_N] = res_lo_d[WIDTH-1];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            op_d      = op;
            cnt_d     = '0;
            acc_d     = '0;
            neg_res_d = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = in_signed && op_is_div(op) && a[WIDTH-1];
            if (op_is_div(op)) begin
                mq_d  = wide_out[WIDTH-1:0];
                opb_d = narrow_out;
            end else begin
                mq_d  = narrow_out;
                opb_d = wide_out[WIDTH-1:0];
            end
`ifdef ALU_DIV_EN
            a_raw_d = a;
`endif
            state_d = short_path ? FIX : RUN;
            hold_d  = short_path;
        end
    end

    // Control state and architectural outputs; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= 1'b0;
            op_q     <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    // Iteration datapath; always loaded on accept before it is read
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        mq_q      <= mq_d;
        opb_q     <= opb_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
`ifdef ALU_DIV_EN
        a_raw_q   <= a_raw_d;
`endif
    end

endmodule
